// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and constants for the multicycle RISC-V core
package cpu_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] INSTR_BYTES      = 32'd4;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_1000;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        DRAIN = 3'd3,
        HOLD  = 3'd4,
        FAULT = 3'd5
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - fetch stage bus: imem read port, redirect port, IR handshake
interface instr_fetch_if;
    import cpu_pkg::*;

    // instruction memory read port
    logic            mem_rd_en;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_rvalid;

    // branch / jump redirect
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    // instruction register towards decode
    logic            ir_valid;
    logic            ir_ready;
    logic [XLEN-1:0] ir;
    logic [XLEN-1:0] ir_pc;

    logic            fetch_fault;

    // fetch stage side
    modport master (
        output mem_rd_en, mem_addr, ir_valid, ir, ir_pc, fetch_fault,
        input  mem_rdata, mem_rvalid, redirect_valid, redirect_pc, ir_ready
    );

    // memory / decode / branch-unit side
    modport slave (
        input  mem_rd_en, mem_addr, ir_valid, ir, ir_pc, fetch_fault,
        output mem_rdata, mem_rvalid, redirect_valid, redirect_pc, ir_ready
    );

endinterface

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage: PC, fetch FSM, IR latch (option: INSTR_FETCH_ALIGN_CHECK_EN)
module instr_fetch
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic          clk,
    input  logic          rst_n,
    instr_fetch_if.master bus
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] ir_q, ir_d;
    logic [XLEN-1:0] ir_pc_q, ir_pc_d;
    logic            ir_valid_q, ir_valid_d;
    logic [XLEN-1:0] redirect_tgt;

`ifdef INSTR_FETCH_ALIGN_CHECK_EN
    logic            fault_q, fault_d;
    logic            redirect_bad;

    // Misaligned targets are kept verbatim so the faulting PC is visible.
    assign redirect_tgt = bus.redirect_pc;
    assign redirect_bad = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
`else
    logic [1:0]      unused_redirect_lsbs;

    // Without the check, targets are silently forced to a word boundary.
    assign redirect_tgt         = {bus.redirect_pc[XLEN-1:2], 2'b00};
    assign unused_redirect_lsbs = bus.redirect_pc[1:0];
`endif

    // Next-state, PC and IR update logic; only one request is ever outstanding.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
`ifdef INSTR_FETCH_ALIGN_CHECK_EN
        fault_d    = fault_q;
`endif

        unique case (state_q)
            IDLE: begin
                state_d = FETCH;
            end

            FETCH: begin
                // The request this cycle still goes out with the old PC;
                // a redirect means its response must be drained.
                state_d = WAIT;
                if (bus.redirect_valid) begin
                    pc_d    = redirect_tgt;
                    state_d = DRAIN;
                end
            end

            WAIT: begin
                if (bus.redirect_valid) begin
                    // Data arriving together with a redirect is stale.
                    pc_d    = redirect_tgt;
                    state_d = bus.mem_rvalid ? FETCH : DRAIN;
                end else if (bus.mem_rvalid) begin
                    ir_d       = bus.mem_rdata;
                    ir_pc_d    = pc_q;
                    ir_valid_d = 1'b1;
                    state_d    = HOLD;
                end
            end

            DRAIN: begin
                // Swallow the stale response; latest redirect target wins.
                if (bus.redirect_valid) begin
                    pc_d = redirect_tgt;
                end
                if (bus.mem_rvalid) begin
                    state_d = FETCH;
                end
            end

            HOLD: begin
                // A redirect beats pc+4 even when the transfer also happens.
                if (bus.redirect_valid) begin
                    pc_d       = redirect_tgt;
                    ir_valid_d = 1'b0;
                    state_d    = FETCH;
                end else if (bus.ir_ready) begin
                    pc_d       = pc_q + INSTR_BYTES;
                    ir_valid_d = 1'b0;
                    state_d    = FETCH;
                end
            end

            default: begin
                state_d = state_q;
            end
        endcase

`ifdef INSTR_FETCH_ALIGN_CHECK_EN
        // A misaligned target parks the stage until reset; any in-flight
        // response is dropped because FAULT ignores mem_rvalid.
        if (redirect_bad && (state_q != IDLE) && (state_q != FAULT)) begin
            fault_d    = 1'b1;
            pc_d       = redirect_tgt;
            ir_valid_d = 1'b0;
            state_d    = FAULT;
        end
`endif
    end

    // State, PC and instruction register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
`ifdef INSTR_FETCH_ALIGN_CHECK_EN
            fault_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
`ifdef INSTR_FETCH_ALIGN_CHECK_EN
            fault_q    <= fault_d;
`endif
        end
    end

    // Outputs are decoded from registered state only.
    assign bus.mem_rd_en = (state_q == FETCH);
    assign bus.mem_addr  = pc_q;
    assign bus.ir_valid  = ir_valid_q;
    assign bus.ir        = ir_q;
    assign bus.ir_pc     = ir_pc_q;
`ifdef INSTR_FETCH_ALIGN_CHECK_EN
    assign bus.fetch_fault = fault_q;
`else
    assign bus.fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - scoreboard testbench for instr_fetch
module tb_instr_fetch;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_fetch_if bus ();

    instr_fetch #(.RESET_PC(32'h0000_1000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;

    // reference model of the architectural fetch stream
    logic [31:0] arch_pc = 32'h0000_1000;
    logic [31:0] out_pc = '0;
    bit          out_live = 0;
    bit          held = 0;
    bit          fault_exp = 0;
    // memory environment
    bit          pending = 0;
    int          lat = 0;
    logic [31:0] resp_addr = '0;
    // run control
    int          cyc = 0;
    int          stall = 0;
    bit          timing_mode = 0;
    int          lat_min = 1, lat_max = 1, ready_pct = 100, redir_pct = 0, redir_mode = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_1004) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: whenever an instruction is presented it must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && bus.ir_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL ir_unexpected: got ir_pc %h ir %h, required no instruction", bus.ir_pc, bus.ir);
            end else begin
                check("ir_pc", bus.ir_pc, exp_q[0].pc);
                check("ir", bus.ir, exp_q[0].word);
                if (bus.ir_ready) begin
                    void'(exp_q.pop_front());
                    stall = 0;
                end
            end
        end
    end

    task automatic respond();
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = $urandom;
        if (pending) begin
            lat--;
            if (lat == 0) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = mem_word(resp_addr);
                pending = 0;
            end
        end
    endtask

    task automatic fire(input logic [31:0] t);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = t;
        redir_mode         = 0;
    endtask

    function automatic logic [31:0] pick_target();
        logic [31:0] t;
        case ($urandom_range(3))
            0: t = 32'h0000_2000;
            1: t = 32'h0000_3000;
            2: t = 32'hFFFF_FFFC;
            default: t = $urandom;
        endcase
`ifdef INSTR_FETCH_ALIGN_CHECK_EN
        t[1:0] = 2'b00;
`endif
        return t;
    endfunction

    task automatic drive_cycle();
        rst_n = 1'b1;
        respond();
        bus.ir_ready       = ($urandom_range(99) < ready_pct);
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = $urandom;
        if (cyc != 0 && !fault_exp) begin
            case (redir_mode)
                1: if (out_live) fire(32'h0000_2000);
                2: if (held) begin bus.ir_ready = 1'b1; fire(32'h0000_3000); end
                3: if (held) begin bus.ir_ready = 1'b0; fire(32'hFFFF_FFFC); end
                4: if (held) begin bus.ir_ready = 1'b0; fire(32'h0000_2002); end
                default: if ($urandom_range(99) < redir_pct) fire(pick_target());
            endcase
        end
    endtask

    // Predict the effect of the coming clock edge from the spec's rules.
    task automatic model_step();
        bit          held_prev = held;
        bit          rdy = bus.ir_ready;
        bit          rv = bus.redirect_valid;
        logic [31:0] tgt;

        check("ir_valid", {31'b0, bus.ir_valid}, {31'b0, held});
        check("fetch_fault", {31'b0, bus.fetch_fault}, {31'b0, fault_exp});
        if (timing_mode) begin
            check("rd_en_timing", {31'b0, bus.mem_rd_en}, {31'b0, (cyc % 3 == 1)});
            check("ir_valid_timing", {31'b0, bus.ir_valid}, {31'b0, (cyc % 3 == 0 && cyc > 0)});
        end

        if (bus.mem_rd_en) begin
            check("mem_addr", bus.mem_addr, arch_pc);
            checks++;
            if (pending || held_prev || fault_exp || cyc == 0) begin
                errors++;
                $display("FAIL rd_en_illegal: request at %h with pending=%0d held=%0d fault=%0d cyc=%0d, required no request",
                         bus.mem_addr, pending, held_prev, fault_exp, cyc);
            end
            out_live  = 1;
            out_pc    = arch_pc;
            pending   = 1;
            lat       = $urandom_range(lat_max, lat_min);
            resp_addr = bus.mem_addr;
        end

        if (bus.mem_rvalid) begin
            if (out_live && !rv) begin
                exp_q.push_back({out_pc, mem_word(out_pc)});
                held  = 1;
                stall = 0;
            end
            out_live = 0;
        end

        if (held_prev && rdy) begin
            held    = 0;
            arch_pc = arch_pc + 32'd4;
        end

        if (rv) begin
            tgt = bus.redirect_pc;
`ifdef INSTR_FETCH_ALIGN_CHECK_EN
            if (tgt[1:0] != 2'b00) fault_exp = 1;
`else
            tgt[1:0] = 2'b00;
`endif
            arch_pc  = tgt;
            out_live = 0;
            if (held_prev && !rdy) begin
                void'(exp_q.pop_back());
                held = 0;
            end
        end

        stall++;
        if (stall == 60 && !fault_exp) begin
            checks++;
            errors++;
            $display("FAIL progress_timeout: no instruction for %0d cycles, required progress", stall);
        end
        cyc++;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2 drive_cycle();
            @(negedge clk);
            #1 model_step();
        end
    endtask

    task automatic do_reset(input int n);
        exp_q.delete();
        held      = 0;
        out_live  = 0;
        fault_exp = 0;
        arch_pc   = 32'h0000_1000;
        cyc       = 0;
        stall     = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
            rst_n              = 1'b0;
            respond();
            bus.ir_ready       = 1'b0;
            bus.redirect_valid = 1'b0;
            @(negedge clk);
            #1;
            if (i >= 1) begin
                check("rst_mem_rd_en", {31'b0, bus.mem_rd_en}, 32'd0);
                check("rst_ir_valid", {31'b0, bus.ir_valid}, 32'd0);
                check("rst_ir", bus.ir, 32'd0);
                check("rst_ir_pc", bus.ir_pc, 32'd0);
                check("rst_fetch_fault", {31'b0, bus.fetch_fault}, 32'd0);
                check("rst_mem_addr", bus.mem_addr, 32'h0000_1000);
            end
        end
    endtask

    initial begin
        bus.mem_rvalid     = 1'b0;
        bus.mem_rdata      = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.ir_ready       = 1'b0;

        do_reset(4);

        // back-to-back fetches: one instruction per 3 cycles
        timing_mode = 1;
        lat_min = 1; lat_max = 1; ready_pct = 100; redir_pct = 0;
        run_cycles(12);
        timing_mode = 0;

        // consumer stalls while an instruction is held
        ready_pct = 0;
        run_cycles(8);
        ready_pct = 100;
        run_cycles(6);

        // redirect during WAIT with slow memory -> drain
        lat_min = 3; lat_max = 3; redir_mode = 1;
        run_cycles(20);

        // redirect in HOLD together with a transfer
        lat_min = 1; lat_max = 1; redir_mode = 2;
        run_cycles(12);

        // wrap from the top of the address space
        redir_mode = 3;
        run_cycles(15);

        // randomized traffic
        lat_min = 1; lat_max = 3; ready_pct = 70; redir_pct = 10; redir_mode = 0;
        run_cycles(3000);

        // reset in the middle of traffic
        do_reset(4);
        run_cycles(1500);

        // misaligned redirect target
        redir_pct = 0; ready_pct = 100; redir_mode = 4;
        run_cycles(20);

        check("scoreboard_drained", exp_q.size(), {31'b0, held});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the multicycle RISC-V core. Holds the program counter, issues single-word reads to instruction memory, and latches each returned word into the instruction register (`ir`). The decode stage and immediate generator consume `ir` through a valid/ready handshake. Branch and jump resolution steer the PC through a redirect port.

## Interface
- `RESET_PC`, default 32'h0000_1000: PC loaded on reset; must be word-aligned.
- `clk` input 1: single clock; all state changes on rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `mem_rd_en` output 1: instruction read request, one cycle per request.
- `mem_addr` output 32: word-aligned fetch address; equals `pc`.
- `mem_rdata` input 32: returned instruction word; sampled only when `mem_rvalid`=1.
- `mem_rvalid` input 1: read data valid; arrives ≥1 cycle after `mem_rd_en`; exactly one per request.
- `redirect_valid` input 1: one-cycle pulse to load a new PC.
- `redirect_pc` input 32: target PC.
- `ir_valid` output 1: `ir`/`ir_pc` hold an unconsumed instruction.
- `ir_ready` input 1: consumer accepts; transfer occurs when `ir_valid && ir_ready`.
- `ir` output 32: latched instruction word.
- `ir_pc` output 32: address the instruction was fetched from.
- `fetch_fault` output 1: misaligned-redirect fault, sticky until reset (see Configuration).

## Operation
- States: IDLE, FETCH, WAIT, DRAIN, HOLD, FAULT.
- IDLE: entered only from reset; unconditionally goes to FETCH next cycle.
- FETCH: `mem_rd_en`=1, `mem_addr`=`pc`. Next state: WAIT.
- WAIT:
  - On `mem_rvalid`: `ir`<=`mem_rdata`, `ir_pc`<=`pc`, `ir_valid`<=1, go to HOLD.
- HOLD: `ir_valid`=1.
  - On `ir_ready`: `pc`<=`pc`+4 (modulo 2^32, wraps to 0), `ir_valid`<=0, go to FETCH.
- Redirect handling (all states except IDLE and FAULT):
  - `pc`<=`redirect_pc`.
  - FETCH: the request this cycle still issues with the old PC, then go to DRAIN.
  - WAIT without `mem_rvalid`: go to DRAIN.
  - WAIT with `mem_rvalid` in the same cycle: discard the data and go to FETCH; `ir` is not updated.
  - DRAIN: stay in DRAIN; the latest redirect wins.
  - HOLD: `ir_valid`<=0 and go to FETCH. If `ir_ready` is also 1, the transfer still counts and the redirect PC still wins over `pc`+4.
- DRAIN: `mem_rd_en`=0. Wait for `mem_rvalid`, discard the data, then go to FETCH with the current `pc`.
- `mem_rvalid` in IDLE, FETCH, HOLD or FAULT is a protocol error and is ignored.
- Never more than one outstanding memory request.

## Timing
- Reset values: state=IDLE, `pc`=`RESET_PC`, `ir`=0, `ir_pc`=0, `ir_valid`=0, `fetch_fault`=0. `mem_rd_en`=0 throughout reset and in IDLE.
- `mem_rd_en` and `mem_addr` are decoded from registered state and `pc`; they have no combinational path from inputs.
- `ir`, `ir_pc` and `ir_valid` are registered. `ir_valid` rises the cycle after `mem_rvalid`.
- `ir` and `ir_pc` are stable while `ir_valid`=1.
- Best-case throughput, with 1-cycle memory and `ir_ready` tied high: one instruction per 3 cycles (FETCH, WAIT, HOLD).
- Reset asserted mid-operation: reset values apply at the next edge. A pending memory response arriving after reset is ignored, because the FSM is in IDLE or FETCH.

## Configuration
- Macro: `INSTR_FETCH_ALIGN_CHECK_EN`.
- Defined: a redirect with `redirect_pc[1:0]`≠0 sets `fetch_fault`<=1 and `pc`<=`redirect_pc` unmodified, and moves the FSM to FAULT. Any in-flight response is discarded. FAULT issues no requests and keeps `ir_valid`=0; only reset exits it.
- Undefined: `redirect_pc[1:0]` is forced to 2'b00, `fetch_fault` is tied to 0, and the FAULT state is not generated.

## Structure
- Shared package `cpu_pkg` holds:
  - `fetch_state_t` enum (IDLE, FETCH, WAIT, DRAIN, HOLD, FAULT);
  - `DEFAULT_RESET_PC` constant (32'h0000_1000);
  - `XLEN`=32;
  - `INSTR_BYTES`=4.
- No sub-module: the PC increment, FSM and IR latch are a single module.

## Test plan
- Reset release, 1-cycle memory, `ir_ready`=1 → requests at 0x1000, 0x1004, 0x1008 every 3 cycles; `ir_pc` matches each address; first `ir_valid` 3 cycles after reset release.
- Hold `ir_ready`=0 for 5 cycles in HOLD with `ir`=0x00500093 → `ir`/`ir_pc` stable, no `mem_rd_en`. Raise `ir_ready` → next request at `ir_pc`+4.
- Redirect to 0x2000 during WAIT with 3-cycle memory latency → stale word not presented; DRAIN until `mem_rvalid`; next request at 0x2000.
- Redirect to 0x3000 in HOLD with `ir_ready`=1 → transfer accepted, next `mem_addr`=0x3000, not `pc`+4.
- `pc`=0xFFFF_FFFC accepted → next request at 0x0000_0000.
- With `INSTR_FETCH_ALIGN_CHECK_EN`: redirect to 0x2002 → `fetch_fault`=1 next cycle, no further `mem_rd_en` until reset. Without it: next fetch at 0x2000.
